// File: rtl/ahb_def_pkg.sv
// Shared AHB-Lite types for the default slave: transfer types, response codes
// and the response-sequencer state encoding.
package ahb_def_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } def_slv_st_t;

endpackage

// File: rtl/ahb_err_log.sv
// Error logger for the default slave: faulting address/direction capture,
// saturating error counter and sticky interrupt with single-cycle clear.
module ahb_err_log #(
  parameter int CNT_W     = 8,
  parameter bit LOG_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             accept,
  input  logic [31:0]      addr,
  input  logic             write,
  input  logic             irq_clr,
  output logic [31:0]      err_addr,
  output logic             err_write,
  output logic [CNT_W-1:0] err_cnt,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A clear in the same cycle as an accept releases the first-error hold.
  logic log_load;
  assign log_load = accept & (!LOG_FIRST | !irq | irq_clr);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_addr  <= '0;
      err_write <= 1'b0;
      err_cnt   <= '0;
      irq       <= 1'b0;
    end else begin
      if (accept && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + 1'b1;
      end
      if (log_load) begin
        err_addr  <= addr;
        err_write <= write;
      end
      if (accept) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ahb_default_slave.sv
// AHB-Lite default slave: answers every out-of-range transfer with the
// two-cycle ERROR response and logs it through ahb_err_log.
module ahb_default_slave
  import ahb_def_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter bit LOG_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hsel_i,
  input  logic [1:0]       htrans_i,
  input  logic [31:0]      haddr_i,
  input  logic             hwrite_i,
  input  logic             hready_i,
  output logic             hready_o,
  output logic             hresp_o,
  output logic [31:0]      err_addr_o,
  output logic             err_write_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             irq_o,
  input  logic             irq_clr_i,
  output logic [1:0]       dbg_state_o
);

  def_slv_st_t state, state_nxt;
  htrans_t     trans;
  logic        accept;

  // Handshake: an address phase is taken only when bus HREADY is high, this
  // slave is selected and the transfer is NONSEQ/SEQ; ERR1 never accepts.
  assign trans  = htrans_t'(htrans_i);
  assign accept = hready_i & hsel_i
                & ((trans == HTRANS_NONSEQ) | (trans == HTRANS_SEQ))
                & (state != ST_ERR1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_ERR1;
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = accept ? ST_ERR1 : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Responses decode the state register only, so no input reaches them.
  always_comb begin
    hready_o = 1'b1;
    hresp_o  = HRESP_OKAY;
    case (state)
      ST_ERR1: begin
        hready_o = 1'b0;
        hresp_o  = HRESP_ERROR;
      end
      ST_ERR2: begin
        hready_o = 1'b1;
        hresp_o  = HRESP_ERROR;
      end
      default: begin
        hready_o = 1'b1;
        hresp_o  = HRESP_OKAY;
      end
    endcase
  end

  assign dbg_state_o = state;

  ahb_err_log #(
    .CNT_W     (CNT_W),
    .LOG_FIRST (LOG_FIRST)
  ) u_err_log (
    .clk       (clk),
    .rstn      (rstn),
    .accept    (accept),
    .addr      (haddr_i),
    .write     (hwrite_i),
    .irq_clr   (irq_clr_i),
    .err_addr  (err_addr_o),
    .err_write (err_write_o),
    .err_cnt   (err_cnt_o),
    .irq       (irq_o)
  );

endmodule
